sonar_scheduler: RTL and testbench
==================================

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

Interface
REQ-001 Parameter NUM_SENSORS, default 3: number of ultrasonic rangers sequenced, range 2..4.
REQ-002 Parameter TRIG_CYCLES, default 1000: trigger pulse width in clk cycles (10 us at 100 MHz).
REQ-003 Parameter SLOT_CYCLES, default 6000000: length of one sensor's measurement slot in clk cycles (60 ms).
REQ-004 Parameter CRASH_THRESH, default 100000: echo width in clk cycles below which an obstacle is a crash.
REQ-005 Parameter CNT_W, default 32: width of the slot timer, echo counter and distance output.
REQ-006 Port clk, input, 1: 100 MHz system clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1: asynchronous, active-high reset.
REQ-008 Port enable, input, 1: 1 runs the round-robin schedule; 0 requests a stop after the current slot.
REQ-009 Port echo, input, NUM_SENSORS: raw asynchronous echo lines, bit i from sensor i.
REQ-010 Port trigger, output, NUM_SENSORS: trigger lines, at most one bit high at a time.
REQ-011 Port crash, output, NUM_SENSORS: registered per-sensor crash flags going to the motor module.
REQ-012 Port any_crash, output, 1: registered OR of crash.
REQ-013 Port dist_valid, output, 1: one-cycle strobe marking a completed slot.
REQ-014 Port dist_sel, output, 2: index of the sensor whose result is on dist_out.
REQ-015 Port dist_out, output, CNT_W: measured echo width in clk cycles, held until the next strobe.
REQ-016 Port timeout, output, 1: held with dist_out; 1 means the slot produced no complete echo.

Function
REQ-017 Each echo bit SHALL pass through a 2-flop synchronizer; every echo reference below means the synchronized value.
REQ-018 The FSM SHALL have states IDLE, TRIG, WAIT_RISE, MEASURE and HOLDOFF.
REQ-019 IDLE: when enable=1, go to TRIG for sensor cur; clear the slot timer.
REQ-020 TRIG: trigger[cur]=1 for exactly TRIG_CYCLES cycles, then go to WAIT_RISE.
REQ-021 WAIT_RISE: on echo[cur] 0->1, clear the echo counter and go to MEASURE.
REQ-022 MEASURE: increment the echo counter each cycle echo[cur]=1; the counter saturates at all-ones and never wraps.
REQ-023 MEASURE, on echo[cur] 1->0: latch the width, set timeout=0, go to HOLDOFF.
REQ-024 The slot timer SHALL count every cycle from TRIG entry; the slot ends at SLOT_CYCLES-1.
REQ-025 Slot end reached in WAIT_RISE or MEASURE: latch dist_out=all-ones, set timeout=1, leave crash[cur] unchanged.
REQ-026 HOLDOFF SHALL wait for slot end, so every slot is exactly SLOT_CYCLES long.
REQ-027 At slot end, one cycle only: dist_valid=1, dist_sel=cur and dist_out/timeout updated.
REQ-028 In the same cycle as REQ-027, crash[cur]=1 if timeout=0 and width<CRASH_THRESH, else crash[cur]=0 if timeout=0.
REQ-029 After slot end, cur SHALL advance to (cur+1) mod NUM_SENSORS.
REQ-030 After slot end, the FSM goes to TRIG if enable=1, else to IDLE.
REQ-031 Deasserting enable mid-slot SHALL NOT shorten the slot or suppress its result.
REQ-032 Echo edges on sensors other than cur SHALL be ignored.
REQ-033 An echo already high on entry to WAIT_RISE SHALL NOT count as a rising edge.
REQ-034 any_crash SHALL update in the cycle after crash changes.

Reset
REQ-035 While rst=1 the FSM SHALL be IDLE and cur=0; trigger, crash, any_crash, dist_valid, dist_sel, dist_out, timeout and all counters=0; synchronizers are cleared.
REQ-036 After rst falls, the first trigger SHALL occur on sensor 0 no earlier than the cycle after enable is sampled high.
REQ-037 Reset asserted mid-slot SHALL drop the trigger immediately and produce no dist_valid for that slot.

Verification (TRIG_CYCLES=10, SLOT_CYCLES=200, CRASH_THRESH=50 for sim)
REQ-038 Scenario: enable=1; echo0 pulse 30 cycles wide -> trigger[0] high 10 cycles; dist_valid with dist_sel=0, dist_out=30, timeout=0; crash[0]=1 and any_crash=1 the next cycle.
REQ-039 Scenario: echo1 pulse 80 cycles wide -> dist_out=80, crash[1]=0, crash[0] unchanged; slot boundaries exactly 200 cycles apart.
REQ-040 Scenario: sensor 2 never echoes -> dist_out=all-ones, timeout=1, crash[2] unchanged; cur wraps to 0.
REQ-041 Scenario: echo0 still high at slot end -> timeout=1; stray echo1 pulses during slot 0 -> no effect.
REQ-042 Scenario: enable drops at cycle 50 of a slot -> slot completes with dist_valid, then IDLE, no further triggers.
REQ-043 Scenario: rst pulse during MEASURE -> all outputs 0 at once; restart begins at sensor 0.

Source files
------------

// File: rtl/sonar_scheduler.sv
// rtl/sonar_scheduler.sv - round-robin ultrasonic ranger sequencer with per-sensor crash flags
module sonar_scheduler #(
    parameter int NUM_SENSORS  = 3,
    parameter int TRIG_CYCLES  = 1000,
    parameter int SLOT_CYCLES  = 6000000,
    parameter int CRASH_THRESH = 100000,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic [NUM_SENSORS-1:0] crash,
    output logic                   any_crash,
    output logic                   dist_valid,
    output logic [1:0]             dist_sel,
    output logic [CNT_W-1:0]       dist_out,
    output logic                   timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] THRESH      = CNT_W'(CRASH_THRESH);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] ALL_ONES    = '1;
    localparam logic [1:0]       LAST_SENSOR = 2'(NUM_SENSORS - 1);

    state_t                 state_q, state_d;
    logic [1:0]             cur_q, cur_d;
    logic [CNT_W-1:0]       slot_q, slot_d;
    logic [CNT_W-1:0]       echo_cnt_q, echo_cnt_d;
    logic [CNT_W-1:0]       width_q, width_d;
    logic [NUM_SENSORS-1:0] crash_q, crash_d;
    logic                   any_crash_q;
    logic                   dist_valid_q, dist_valid_d;
    logic [1:0]             dist_sel_q, dist_sel_d;
    logic [CNT_W-1:0]       dist_out_q, dist_out_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_SENSORS-1:0] echo_s1_q, echo_s2_q, echo_prev_q;
    logic                   cur_echo, cur_prev, slot_end;

    // Two-flop synchronizer plus one history flop for edge detection on the synchronized echo
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_s1_q   <= '0;
            echo_s2_q   <= '0;
            echo_prev_q <= '0;
        end else begin
            echo_s1_q   <= echo;
            echo_s2_q   <= echo_s1_q;
            echo_prev_q <= echo_s2_q;
        end
    end

    assign cur_echo = echo_s2_q[cur_q];
    assign cur_prev = echo_prev_q[cur_q];
    assign slot_end = (state_q != S_IDLE) && (slot_q == SLOT_LAST);

    // Next-state and result logic; slot end takes priority over every in-slot transition
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        slot_d       = slot_q;
        echo_cnt_d   = echo_cnt_q;
        width_d      = width_q;
        crash_d      = crash_q;
        dist_valid_d = 1'b0;
        dist_sel_d   = dist_sel_q;
        dist_out_d   = dist_out_q;
        timeout_d    = timeout_q;

        if (state_q == S_IDLE) begin
            slot_d = '0;
            if (enable) begin
                state_d = S_TRIG;
            end
        end else if (slot_end) begin
            dist_valid_d = 1'b1;
            dist_sel_d   = cur_q;
            if (state_q == S_HOLDOFF) begin
                dist_out_d     = width_q;
                timeout_d      = 1'b0;
                crash_d[cur_q] = (width_q < THRESH);
            end else begin
                dist_out_d = ALL_ONES;
                timeout_d  = 1'b1;
            end
            cur_d   = (cur_q == LAST_SENSOR) ? 2'd0 : cur_q + 2'd1;
            slot_d  = '0;
            state_d = enable ? S_TRIG : S_IDLE;
        end else begin
            slot_d = slot_q + ONE;
            case (state_q)
                S_TRIG: begin
                    if (slot_q == TRIG_LAST) begin
                        state_d = S_WAIT_RISE;
                    end
                end
                S_WAIT_RISE: begin
                    // The edge cycle is itself the first high cycle of the echo
                    if (cur_echo && !cur_prev) begin
                        echo_cnt_d = ONE;
                        state_d    = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (cur_echo) begin
                        if (echo_cnt_q != ALL_ONES) begin
                            echo_cnt_d = echo_cnt_q + ONE;
                        end
                    end else begin
                        width_d = echo_cnt_q;
                        state_d = S_HOLDOFF;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_q        <= 2'd0;
            slot_q       <= '0;
            echo_cnt_q   <= '0;
            width_q      <= '0;
            crash_q      <= '0;
            any_crash_q  <= 1'b0;
            dist_valid_q <= 1'b0;
            dist_sel_q   <= 2'd0;
            dist_out_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            slot_q       <= slot_d;
            echo_cnt_q   <= echo_cnt_d;
            width_q      <= width_d;
            crash_q      <= crash_d;
            any_crash_q  <= |crash_q;
            dist_valid_q <= dist_valid_d;
            dist_sel_q   <= dist_sel_d;
            dist_out_q   <= dist_out_d;
            timeout_q    <= timeout_d;
        end
    end

    // Trigger decodes straight from state so reset drops it without waiting for a clock
    always_comb begin
        trigger = '0;
        if (state_q == S_TRIG) begin
            trigger[cur_q] = 1'b1;
        end
    end

    assign crash      = crash_q;
    assign any_crash  = any_crash_q;
    assign dist_valid = dist_valid_q;
    assign dist_sel   = dist_sel_q;
    assign dist_out   = dist_out_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// tb/tb_sonar_scheduler.sv - directed self-checking bench for sonar_scheduler
module tb_sonar_scheduler;

    localparam int NS = 3;
    localparam int TC = 10;
    localparam int SC = 200;
    localparam int CT = 50;
    localparam int CW = 32;
    localparam logic [CW-1:0] ONES = '1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [NS-1:0] echo;
    logic [NS-1:0] trigger;
    logic [NS-1:0] crash;
    logic          any_crash;
    logic          dist_valid;
    logic [1:0]    dist_sel;
    logic [CW-1:0] dist_out;
    logic          timeout;

    int errors = 0;
    int checks = 0;

    int   trig_cnt, other_cnt, dv_cnt, idle_trig, idle_dv;
    logic any_at1;

    sonar_scheduler #(
        .NUM_SENSORS (NS),
        .TRIG_CYCLES (TC),
        .SLOT_CYCLES (SC),
        .CRASH_THRESH(CT),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .echo      (echo),
        .trigger   (trigger),
        .crash     (crash),
        .any_crash (any_crash),
        .dist_valid(dist_valid),
        .dist_sel  (dist_sel),
        .dist_out  (dist_out),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one full slot starting at its first cycle; ends on the first cycle of the next slot
    task automatic run_slot(input int sensor, input int e_start, input int e_width,
                            input int stray, input int en_drop,
                            output int t_cnt, output int o_cnt, output int v_cnt,
                            output logic any1);
        logic [NS-1:0] mask;
        mask  = NS'(1) << sensor;
        t_cnt = 0;
        o_cnt = 0;
        v_cnt = 0;
        any1  = 1'b0;
        for (int p = 0; p < SC; p++) begin
            if (trigger[sensor]) t_cnt++;
            if ((trigger & ~mask) != '0) o_cnt++;
            if (p >= 1 && dist_valid) v_cnt++;
            if (p == 1) any1 = any_crash;
            if (e_start >= 0 && p == e_start) echo[sensor] = 1'b1;
            if (e_start >= 0 && p == e_start + e_width) echo[sensor] = 1'b0;
            if (stray >= 0) begin
                if (p == 30 || p == 100) echo[stray] = 1'b1;
                if (p == 40 || p == 110) echo[stray] = 1'b0;
            end
            if (p == en_drop) enable = 1'b0;
            step(1);
        end
        echo = '0;
    endtask

    task automatic check_result(input string tag, input logic [1:0] sel, input logic [CW-1:0] dout,
                                input logic to, input logic [NS-1:0] cr, input logic [NS-1:0] trig);
        check({tag, "_valid"}, dist_valid, 1'b1);
        check({tag, "_sel"}, dist_sel, sel);
        check({tag, "_out"}, dist_out, dout);
        check({tag, "_timeout"}, timeout, to);
        check({tag, "_crash"}, crash, cr);
        check({tag, "_trigger"}, trigger, trig);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        echo   = '0;
        step(3);
        check("rst_trigger", trigger, 3'b000);
        check("rst_crash", crash, 3'b000);
        check("rst_any_crash", any_crash, 1'b0);
        check("rst_valid", dist_valid, 1'b0);
        check("rst_sel", dist_sel, 2'd0);
        check("rst_out", dist_out, 32'd0);
        check("rst_timeout", timeout, 1'b0);

        rst    = 1'b0;
        enable = 1'b1;
        check("idle_no_trigger", trigger, 3'b000);
        step(1);
        check("first_trigger", trigger, 3'b001);

        // Sensor 0: 30-cycle echo -> crash
        run_slot(0, 20, 30, -1, -1, trig_cnt, other_cnt, dv_cnt, any_at1);
        check("s0_trig_width", trig_cnt, TC);
        check("s0_other_trig", other_cnt, 0);
        check("s0_no_early_valid", dv_cnt, 0);
        check_result("s0", 2'd0, 32'd30, 1'b0, 3'b001, 3'b010);

        // Sensor 1: 80-cycle echo -> no crash
        run_slot(1, 20, 80, -1, -1, trig_cnt, other_cnt, dv_cnt, any_at1);
        check("s0_any_crash_next", any_at1, 1'b1);
        check("s1_trig_width", trig_cnt, TC);
        check("s1_slot_len", dv_cnt, 0);
        check_result("s1", 2'd1, 32'd80, 1'b0, 3'b001, 3'b100);

        // Sensor 2: no echo -> timeout, wrap to sensor 0
        run_slot(2, -1, 0, -1, -1, trig_cnt, other_cnt, dv_cnt, any_at1);
        check("s2_trig_width", trig_cnt, TC);
        check("s2_slot_len", dv_cnt, 0);
        check_result("s2", 2'd2, ONES, 1'b1, 3'b001, 3'b001);

        // Sensor 0 again: echo still high at slot end, stray sensor-1 pulses
        run_slot(0, 150, 1000, 1, -1, trig_cnt, other_cnt, dv_cnt, any_at1);
        check("s0b_other_trig", other_cnt, 0);
        check("s0b_slot_len", dv_cnt, 0);
        check_result("s0b", 2'd0, ONES, 1'b1, 3'b001, 3'b010);

        // Sensor 1: enable drops mid-slot; slot still completes, then idle
        run_slot(1, 20, 20, -1, 50, trig_cnt, other_cnt, dv_cnt, any_at1);
        check("s1b_trig_width", trig_cnt, TC);
        check("s1b_slot_len", dv_cnt, 0);
        check_result("s1b", 2'd1, 32'd20, 1'b0, 3'b011, 3'b000);

        idle_trig = 0;
        idle_dv   = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (trigger != '0) idle_trig++;
            if (dist_valid) idle_dv++;
        end
        check("idle_triggers", idle_trig, 0);
        check("idle_valids", idle_dv, 0);
        check("idle_any_crash", any_crash, 1'b1);

        // Resume on sensor 2, then reset during MEASURE
        enable = 1'b1;
        step(1);
        check("resume_trigger", trigger, 3'b100);
        step(20);
        echo[2] = 1'b1;
        step(20);
        rst = 1'b1;
        #1;
        check("mid_rst_trigger", trigger, 3'b000);
        check("mid_rst_crash", crash, 3'b000);
        check("mid_rst_any_crash", any_crash, 1'b0);
        check("mid_rst_valid", dist_valid, 1'b0);
        check("mid_rst_out", dist_out, 32'd0);
        check("mid_rst_timeout", timeout, 1'b0);
        step(2);
        rst  = 1'b0;
        echo = '0;
        step(1);
        check("restart_trigger", trigger, 3'b001);
        check("restart_no_valid", dist_valid, 1'b0);
        run_slot(0, -1, 0, -1, -1, trig_cnt, other_cnt, dv_cnt, any_at1);
        check("restart_slot_len", dv_cnt, 0);
        check_result("restart", 2'd0, ONES, 1'b1, 3'b000, 3'b010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
